std_gray2bin_arb: RTL and testbench

//   Round-robin arbiter that shares one Gray-to-binary converter datapath among NREQ requesters.

---
 rtl/std_gray2bin_arb.sv | 134 +++++++++++++
 tb/tb_std_gray2bin_arb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/std_gray2bin_arb.sv
// Round-robin arbiter feeding one shared Gray-to-binary converter.
// The winning word is converted and registered with its requester ID.
module std_gray2bin_arb #(
    parameter int DW = 32,
    parameter int NREQ = 4,
    localparam int IDW = ($clog2(NREQ) > 0) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_gray,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_bin,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IDW-1:0]  rr_ptr_r;
    logic            found_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [DW-1:0]   grant_word_s;
    logic            can_accept_s;
    logic            grant_s;
    logic            out_valid_r;
    logic [DW-1:0]   out_bin_r;
    logic [IDW-1:0]  out_id_r;

    // Each binary bit is the XOR of all Gray bits at or above it; MSB passes through.
    function automatic logic [DW-1:0] gray2bin(input logic [DW-1:0] g);
        logic [DW-1:0] b;
        b[DW-1] = g[DW-1];
        for (int k = DW - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Priority search starting at the round-robin pointer, wrapping to 0.
    always_comb begin
        found_s      = 1'b0;
        grant_idx_s  = '0;
        grant_word_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr_r) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found_s && req_valid[idx]) begin
                found_s      = 1'b1;
                grant_idx_s  = IDW'(idx);
                grant_word_s = req_gray[idx*DW +: DW];
            end else begin
                found_s      = found_s;
            end
        end
    end

    // Handshake: the result slot is free when empty or being drained this cycle.
    always_comb begin
        can_accept_s = !rst && ((state_r == ST_EMPTY) || out_ready);
        grant_s      = found_s && can_accept_s;
        req_ready    = '0;
        if (grant_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Result-slot FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (grant_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready && !grant_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State, pointer and result registers; the result only changes on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            rr_ptr_r    <= '0;
            out_valid_r <= 1'b0;
            out_bin_r   <= '0;
            out_id_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s == ST_FULL);
            if (grant_s) begin
                out_bin_r <= gray2bin(grant_word_s);
                out_id_r  <= grant_idx_s;
                if (int'(grant_idx_s) == NREQ - 1) begin
                    rr_ptr_r <= '0;
                end else begin
                    rr_ptr_r <= IDW'(int'(grant_idx_s) + 1);
                end
            end else begin
                out_bin_r <= out_bin_r;
                out_id_r  <= out_id_r;
                rr_ptr_r  <= rr_ptr_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_bin   = out_bin_r;
    assign out_id    = out_id_r;

endmodule

// File: tb/tb_std_gray2bin_arb.sv
// Randomized bench for std_gray2bin_arb with a cycle-level reference model.
module tb_std_gray2bin_arb;
    localparam int DW   = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_gray;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_bin;
    logic [IDW-1:0]       out_id;
    logic                 out_ready;

    int checks = 0;
    int failures = 0;

    bit            m_full;
    logic [DW-1:0] m_bin;
    int            m_id;
    int            m_rr;

    always #5 clk = ~clk;

    std_gray2bin_arb #(.DW(DW), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready), .out_valid(out_valid), .out_bin(out_bin),
        .out_id(out_id), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_g2b(input logic [DW-1:0] g);
        logic [DW-1:0] r;
        for (int k = 0; k < DW; k++) r[k] = ^(g >> k);
        return r;
    endfunction

    // One clock: check req_ready before the edge, advance the model, check outputs after.
    task automatic step();
        int g;
        bit can;
        logic [NREQ-1:0] er;
        logic [DW-1:0] w;
        #3;
        can = !rst && (!m_full || out_ready);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
        end
        er = '0;
        if (g >= 0 && can) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        w = req_gray[((g < 0) ? 0 : g)*DW +: DW];
        @(posedge clk);
        if (rst) begin
            m_full = 1'b0; m_bin = '0; m_id = 0; m_rr = 0;
        end else if (g >= 0 && can) begin
            m_full = 1'b1; m_bin = ref_g2b(w); m_id = g; m_rr = (g + 1) % NREQ;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_full));
        if (m_full) begin
            check("out_bin", 64'(out_bin), 64'(m_bin));
            check("out_id", 64'(out_id), 64'(m_id));
        end
    endtask

    task automatic rand_words();
        for (int i = 0; i < NREQ; i++) req_gray[i*DW +: DW] = $urandom();
    endtask

    initial begin
        logic [DW-1:0]  hold_bin;
        logic [IDW-1:0] hold_id;
        m_full = 1'b0; m_bin = '0; m_id = 0; m_rr = 0;
        rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
        rand_words();

        // reset with all requesters valid
        step(); step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_bin", 64'(out_bin), 64'd0);
        check("rst_id", 64'(out_id), 64'd0);

        // single conversion
        rst = 1'b0; req_valid = 4'b0100; req_gray[2*DW +: DW] = 32'h0000_0003;
        step();
        check("single_bin", 64'(out_bin), 64'h2);
        check("single_id", 64'(out_id), 64'd2);
        check("single_valid", 64'(out_valid), 64'd1);

        // MSB corner and zero
        req_valid = 4'b0001; req_gray[0 +: DW] = 32'h8000_0000;
        step();
        check("msb_bin", 64'(out_bin), 64'hFFFF_FFFF);
        req_gray[0 +: DW] = 32'h0000_0000;
        step();
        check("zero_bin", 64'(out_bin), 64'h0);

        // move the pointer back to 0, then round-robin with all valid
        req_valid = 4'b1000; step();
        req_valid = 4'hF;
        for (int n = 0; n < 6; n++) begin
            rand_words();
            step();
            check("rr_id", 64'(out_id), 64'(n % NREQ));
            check("rr_valid", 64'(out_valid), 64'd1);
        end

        // backpressure: outputs frozen, nobody granted
        out_ready = 1'b0;
        hold_bin = out_bin; hold_id = out_id;
        for (int n = 0; n < 5; n++) begin
            rand_words();
            step();
            check("bp_bin", 64'(out_bin), 64'(hold_bin));
            check("bp_id", 64'(out_id), 64'(hold_id));
        end
        out_ready = 1'b1; req_valid = 4'b0010;
        step();
        check("refill_id", 64'(out_id), 64'd1);
        check("refill_valid", 64'(out_valid), 64'd1);

        // mid-operation reset after pointer reaches 3
        req_valid = 4'b0100; step();
        rst = 1'b1; req_valid = 4'hF; out_ready = 1'b0;
        step();
        check("midrst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        check("midrst_first_id", 64'(out_id), 64'd0);

        // random scoreboard
        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            req_valid = NREQ'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            rand_words();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
